// File: rtl/prbs7_checker_if.sv
// Bit-stream and status bundle between a PRBS7 receive source and the checker.
// The checker sits on the slave side; the source or bench uses the master side.
interface prbs7_checker_if #(
  parameter int CNT_W = 32
);
  logic             in;
  logic             en;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output in, en, clr_cnt,
    input  locked, err, err_cnt, bit_cnt
  );

  modport slave (
    input  in, en, clr_cnt,
    output locked, err, err_cnt, bit_cnt
  );
endinterface

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) receive checker: seeds from the data,
// hunts for a consistent sequence, then checks against a free-running local LFSR.
module prbs7_checker #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 8,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  prbs7_checker_if.slave  bus
);

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

  localparam logic [7:0]       LOCK_TARGET = 8'(LOCK_CNT);
  localparam logic [7:0]       LOSS_TARGET = 8'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [6:0]       sr_q, sr_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [2:0]       seed_cnt_q, seed_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [6:0]       win_cnt_q, win_cnt_d;
  logic [7:0]       win_err_q, win_err_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic       predict;
  logic       match;
  logic       expect_bit;
  logic       bit_err;
  logic [7:0] win_err_sum;

  // An all-zero history never counts as a match, so a stuck-low line cannot lock.
  assign predict     = sr_q[6] ^ sr_q[5];
  assign match       = (bus.in == predict) && (sr_q != 7'd0);
  assign expect_bit  = lfsr_q[6] ^ lfsr_q[5];
  assign bit_err     = bus.in ^ expect_bit;
  assign win_err_sum = win_err_q + {7'd0, bit_err};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    lfsr_d      = lfsr_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    if (bus.en) begin
      sr_d = {sr_q[5:0], bus.in};
      case (state_q)
        SEED: begin
          if (seed_cnt_q == 3'd6) begin
            state_d     = HUNT;
            seed_cnt_d  = 3'd0;
            match_cnt_d = 8'd0;
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end
        HUNT: begin
          if (!match) begin
            match_cnt_d = 8'd0;
          end else if (match_cnt_q + 8'd1 == LOCK_TARGET) begin
            state_d     = LOCKED;
            match_cnt_d = 8'd0;
            lfsr_d      = {sr_q[5:0], bus.in};
            win_cnt_d   = 7'd0;
            win_err_d   = 8'd0;
          end else begin
            match_cnt_d = match_cnt_q + 8'd1;
          end
        end
        LOCKED: begin
          lfsr_d = {lfsr_q[5:0], expect_bit};
          err_d  = bit_err;
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_err && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
          // Loss of lock wins over the window wrap on the same bit.
          if (bit_err && win_err_sum == LOSS_TARGET) begin
            state_d    = SEED;
            seed_cnt_d = 3'd0;
          end else if (win_cnt_q == 7'd127) begin
            win_cnt_d = 7'd0;
            win_err_d = 8'd0;
          end else begin
            win_cnt_d = win_cnt_q + 7'd1;
            win_err_d = win_err_sum;
          end
        end
        default: state_d = SEED;
      endcase
    end

    if (bus.clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      sr_q        <= 7'd0;
      lfsr_q      <= 7'd0;
      seed_cnt_q  <= 3'd0;
      match_cnt_q <= 8'd0;
      win_cnt_q   <= 7'd0;
      win_err_q   <= 8'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      lfsr_q      <= lfsr_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign bus.locked  = (state_q == LOCKED);
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: a 32-bit-counter instance and a 4-bit-counter
// instance see identical stimulus; expected values are hand-derived constants.
module tb_prbs7_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prbs7_checker_if #(.CNT_W(32)) ifa ();
  prbs7_checker_if #(.CNT_W(4))  ifb ();

  prbs7_checker #(.LOCK_CNT(16), .LOSS_CNT(8), .CNT_W(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  prbs7_checker #(.LOCK_CNT(16), .LOSS_CNT(8), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  int         compareCount = 0;
  int         failCount    = 0;
  int         errSeen      = 0;
  logic [6:0] genState     = 7'h7F;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle on both instances, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic b_in, input logic b_en, input logic b_clr);
    ifa.in = b_in;  ifa.en = b_en;  ifa.clr_cnt = b_clr;
    ifb.in = b_in;  ifb.en = b_en;  ifb.clr_cnt = b_clr;
    @(posedge clk);
    #1;
    if (ifa.err === 1'b1) errSeen++;
  endtask

  task automatic nextBit(output logic b);
    b = genState[6] ^ genState[5];
    genState = {genState[5:0], b};
  endtask

  task automatic sendClean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      nextBit(b);
      applyStimulus(b, 1'b1, 1'b0);
    end
  endtask

  task automatic sendFlipped(input logic b_clr);
    logic b;
    nextBit(b);
    applyStimulus(~b, 1'b1, b_clr);
  endtask

  task automatic sendGapped(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom), 1'b0, 1'b0);
      applyStimulus(1'($urandom), 1'b0, 1'b0);
      nextBit(b);
      applyStimulus(b, 1'b1, 1'b0);
    end
  endtask

  task automatic pulseReset;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int   firstOne;
    int   lockAt;
    logic lockedSeen;
    logic b;

    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_locked",  ifa.locked,  0);
    checkOutput("reset_err",     ifa.err,     0);
    checkOutput("reset_err_cnt", ifa.err_cnt, 0);
    checkOutput("reset_bit_cnt", ifa.bit_cnt, 0);
    rst = 1'b0;

    // Clean stream: locked rises on the 23rd valid bit.
    sendClean(22);
    checkOutput("lock_bit22", ifa.locked, 0);
    sendClean(1);
    checkOutput("lock_bit23", ifa.locked, 1);
    errSeen = 0;
    sendClean(1000);
    checkOutput("clean_bit_cnt", ifa.bit_cnt, 1000);
    checkOutput("clean_err_cnt", ifa.err_cnt, 0);
    checkOutput("clean_err_pulses", errSeen, 0);

    // One flipped bit gives exactly one error thanks to the free-running LFSR.
    sendClean(499);
    sendFlipped(1'b0);
    checkOutput("flip_err", ifa.err, 1);
    sendClean(100);
    checkOutput("flip_err_pulses", errSeen, 1);
    checkOutput("flip_err_cnt", ifa.err_cnt, 1);
    checkOutput("flip_bit_cnt", ifa.bit_cnt, 1600);
    checkOutput("flip_locked", ifa.locked, 1);

    // Clear on an error bit: counters zero, err still pulses.
    sendFlipped(1'b1);
    checkOutput("clr_err_cnt", ifa.err_cnt, 0);
    checkOutput("clr_bit_cnt", ifa.bit_cnt, 0);
    checkOutput("clr_err", ifa.err, 1);
    checkOutput("clr_locked", ifa.locked, 1);

    // Align to a fresh 128-bit window (locked bit 1792), then 8 errors in 80 bits.
    sendClean(191);
    for (int i = 1; i <= 8; i++) begin
      sendClean(9);
      sendFlipped(1'b0);
      if (i == 7) begin
        checkOutput("loss_7th_locked", ifa.locked, 1);
        checkOutput("loss_7th_err_cnt", ifa.err_cnt, 7);
      end
    end
    checkOutput("loss_8th_locked", ifa.locked, 0);
    checkOutput("loss_8th_err", ifa.err, 1);
    checkOutput("loss_8th_err_cnt", ifa.err_cnt, 8);

    sendClean(22);
    checkOutput("relock_bit22", ifa.locked, 0);
    sendClean(1);
    checkOutput("relock_bit23", ifa.locked, 1);
    checkOutput("relock_err_cnt", ifa.err_cnt, 8);

    // Stuck-low line never locks; a real PRBS afterwards locks promptly.
    pulseReset();
    lockedSeen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (ifa.locked === 1'b1) lockedSeen = 1'b1;
    end
    checkOutput("stuck_never_locked", lockedSeen, 0);
    checkOutput("stuck_err_cnt", ifa.err_cnt, 0);
    genState = 7'h7F;
    firstOne = -1;
    lockAt   = -1;
    for (int k = 1; k <= 40 && lockAt < 0; k++) begin
      nextBit(b);
      applyStimulus(b, 1'b1, 1'b0);
      if (b && firstOne < 0) firstOne = k;
      if (ifa.locked === 1'b1) lockAt = k;
    end
    checkOutput("stuck_relock_in_time",
                32'((lockAt > 0) && (firstOne > 0) && (lockAt - firstOne <= 22)), 1);
    checkOutput("stuck_relock_err_cnt", ifa.err_cnt, 0);

    // Valid bits only one cycle in three.
    pulseReset();
    sendGapped(22);
    checkOutput("gap_bit22", ifa.locked, 0);
    sendGapped(1);
    checkOutput("gap_bit23", ifa.locked, 1);
    sendGapped(30);
    checkOutput("gap_bit_cnt", ifa.bit_cnt, 30);
    checkOutput("gap_err_cnt", ifa.err_cnt, 0);
    applyStimulus(1'($urandom), 1'b0, 1'b0);
    sendFlipped(1'b0);
    checkOutput("gap_err_pulse", ifa.err, 1);
    applyStimulus(1'($urandom), 1'b0, 1'b0);
    checkOutput("gap_err_after_idle", ifa.err, 0);

    // 20 errors spaced 20 bits apart stay under the loss threshold.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sat_clr", ifb.err_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      sendClean(19);
      sendFlipped(1'b0);
    end
    checkOutput("sat_err_cnt_w4", ifb.err_cnt, 15);
    checkOutput("sat_bit_cnt_w4", ifb.bit_cnt, 15);
    checkOutput("sat_err_cnt_w32", ifa.err_cnt, 20);
    checkOutput("sat_bit_cnt_w32", ifa.bit_cnt, 400);
    checkOutput("sat_locked", ifa.locked, 1);

    // Reset mid-lock overrides en and clr_cnt.
    pulseReset();
    checkOutput("rst_mid_locked", ifa.locked, 0);
    checkOutput("rst_mid_err", ifa.err, 0);
    checkOutput("rst_mid_err_cnt", ifa.err_cnt, 0);
    checkOutput("rst_mid_bit_cnt", ifa.bit_cnt, 0);
    checkOutput("rst_mid_err_cnt_w4", ifb.err_cnt, 0);
    sendClean(22);
    checkOutput("rst_relock_bit22", ifa.locked, 0);
    sendClean(1);
    checkOutput("rst_relock_bit23", ifa.locked, 1);
    checkOutput("rst_relock_bit_cnt", ifa.bit_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Receive-side PRBS7 checker that consumes the sliced bit stream recovered after the channel and reports link bit errors. It sits downstream of the channel and the receiver slicer, closing the loop on the prbs7 → bit2pwl → channel chain. It self-synchronizes to an x^7+x^6+1 sequence, declares lock, then compares against a free-running local LFSR. It reports per-bit error pulses, saturating error/bit counters, and loss of lock.

## Interface
- LOCK_CNT, 16: consecutive correct predictions in HUNT required to lock (1..255)
- LOSS_CNT, 8: errors within one 128-bit window that force loss of lock (1..128)
- CNT_W, 32: width of err_cnt and bit_cnt
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in  in  1  recovered data bit, sampled when en=1
- en  in  1  data-valid qualifier; en=0 cycles are ignored entirely (no shift, no count)
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt
- locked  out  1  high while in LOCKED state
- err  out  1  one-cycle pulse: the bit sampled on the previous edge was wrong (LOCKED only)
- err_cnt  out  CNT_W  saturating error count since reset/clear
- bit_cnt  out  CNT_W  saturating count of bits checked in LOCKED

## Operation
- Receive shift register sr[6:0]; on each valid bit: sr <= {sr[5:0], in}. Prediction p = sr[6]^sr[5].
- States: SEED, HUNT, LOCKED. Reset enters SEED.
- SEED: shift in 7 valid bits (seed counter 0..6). After the 7th bit, go to HUNT with match_cnt=0.
- HUNT, per valid bit: match if in==p and sr!=7'b0; otherwise mismatch. The all-zero sr always counts as a mismatch, so a stuck-0 line never locks. Match increments match_cnt; mismatch clears it. sr shifts in the received bit regardless.
- When a match brings match_cnt to LOCK_CNT: go to LOCKED, load local LFSR L <= {sr[5:0], in}, and clear win_cnt and win_err.
- LOCKED, per valid bit:
  - expected e = L[6]^L[5]; L <= {L[5:0], e}. L never reloads from data, so one flipped input bit gives exactly one error.
  - error = in ^ e. The bit increments bit_cnt; an error also sets err and increments err_cnt.
- Loss window:
  - win_cnt counts valid bits 0..127 in LOCKED; win_err counts errors in the window, including the current bit.
  - If win_err+error reaches LOSS_CNT, go to SEED. The loss takes priority over the window wrap.
  - Otherwise, on the 128th bit (win_cnt==127), clear win_cnt and win_err.
- Counters saturate at 2^CNT_W-1 independently. They increment only in LOCKED and hold their values across loss of lock.
- clr_cnt=1: err_cnt and bit_cnt become 0 on that edge. Clear has priority; a concurrent bit is not counted. err and the FSM are unaffected.
- rst=1: state SEED, sr=0, L=0, all internal counters 0. Outputs: locked=0, err=0, err_cnt=0, bit_cnt=0. This holds identically if asserted mid-lock; rst overrides clr_cnt and en.

## Timing
- All outputs are registered and reflect the valid bit sampled on the preceding edge.
- err is high for exactly the one cycle after the erroneous bit's edge. It is 0 on any cycle following an en=0 cycle.
- Lock latency on a clean stream: locked rises on the edge sampling valid bit 7+LOCK_CNT, i.e. bit 23 at the default.
- Loss latency: locked falls on the edge sampling the error that reaches LOSS_CNT. That same bit still pulses err and counts.
- The lock transition bit counts toward neither bit_cnt nor errors. Checking starts with the next valid bit.
- en may toggle every cycle; behaviour depends only on the sequence of valid bits.

## Test plan
- Clean PRBS7 from prbs7, en=1, defaults → locked=1 after 23rd bit. Then 1000 more bits → bit_cnt=1000, err_cnt=0, err never high.
- Locked, flip one bit at index 500 → exactly one err pulse, err_cnt=1. Without the free-running LFSR this would give 3 errors.
- Locked, inject 8 errors within 100 bits → locked=0 on the 8th error edge, err_cnt=8. Clean stream → relock 23 bits later, err_cnt still 8.
- in=0 constant for 500 bits → never locked, err_cnt=0. Then switch to PRBS7 → lock within 7+16 bits of the first nonzero sr.
- en gapped at 1-of-3 cycles on clean PRBS7 → lock after 23 valid bits, zero errors. Also clr_cnt coincident with an error bit → err_cnt=0 next cycle, err=1.
- CNT_W=4 with 20 errors spread below the loss threshold → err_cnt saturates at 15. Then rst mid-lock → all outputs 0 next cycle; reacquisition is normal.
